// File: rtl/stream_mux.sv
// stream_mux: CHANNELS-to-1 valid/ready stream multiplexer with fixed-select or round-robin
// arbitration and a registered output stage. Define STREAM_MUX_PKT_LOCK_EN for packet-locked round-robin.
module stream_mux #(
    parameter int N        = 32,
    parameter int CHANNELS = 16,
    parameter int SW       = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    input  logic                  mode,
    input  logic [SW-1:0]         sel,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [CHANNELS-1:0]   in_last,
    output logic                  out_last,
`endif
    output logic [N-1:0]          out_data,
    output logic [SW-1:0]         out_chan,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int            PW   = SW + 1;
    localparam logic [PW-1:0] CH_W = PW'(CHANNELS);

    logic [SW-1:0] r_rr_ptr;
    logic [N-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_valid;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic          r_lock;
    logic [SW-1:0] r_lock_chan;
    logic          r_out_last;
`endif

    logic          w_can_load;
    logic          w_sel_gnt;
    logic          w_rr_gnt;
    logic [SW-1:0] w_rr_idx;
    logic [PW-1:0] w_sum;
    logic [SW-1:0] w_scan;
    logic          w_grant;
    logic [SW-1:0] w_gnt;
    logic          w_load;
    logic [PW-1:0] w_inc;
    logic [SW-1:0] w_ptr_next;
    logic [N-1:0]  w_word;

    assign w_can_load = !r_out_valid || out_ready;
    assign w_load     = w_grant && w_can_load;

    // Fixed-select grant; indices at or beyond CHANNELS never grant.
    always_comb begin
        w_sel_gnt = 1'b0;
        if ({1'b0, sel} < CH_W) begin
            w_sel_gnt = in_valid[sel];
        end else begin
            w_sel_gnt = 1'b0;
        end
    end

    // Round-robin scan from r_rr_ptr upward; the extra bit keeps ptr+k from overflowing at CHANNELS=2^SW.
    always_comb begin
        w_rr_gnt = 1'b0;
        w_rr_idx = '0;
        w_sum    = '0;
        w_scan   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_sum  = {1'b0, r_rr_ptr} + PW'(k);
            w_scan = (w_sum >= CH_W) ? SW'(w_sum - CH_W) : SW'(w_sum);
            if (!w_rr_gnt && in_valid[w_scan]) begin
                w_rr_gnt = 1'b1;
                w_rr_idx = w_scan;
            end else begin
                w_rr_gnt = w_rr_gnt;
            end
        end
    end

    // Final grant: mode picks the source; an open packet pins round-robin to its channel.
    always_comb begin
        w_grant = 1'b0;
        w_gnt   = '0;
        if (!mode) begin
            w_grant = w_sel_gnt;
            w_gnt   = sel;
`ifdef STREAM_MUX_PKT_LOCK_EN
        end else if (r_lock) begin
            w_grant = in_valid[r_lock_chan];
            w_gnt   = r_lock_chan;
`endif
        end else begin
            w_grant = w_rr_gnt;
            w_gnt   = w_rr_idx;
        end
    end

    // Pointer successor of the granted channel, wrapped for non-power-of-two CHANNELS.
    always_comb begin
        w_inc      = {1'b0, w_gnt} + {{SW{1'b0}}, 1'b1};
        w_ptr_next = '0;
        if (w_inc >= CH_W) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = SW'(w_inc);
        end
    end

    // Word of the granted channel.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt == SW'(i)) begin
                w_word = in_data[i*N +: N];
            end else begin
                w_word = w_word;
            end
        end
    end

    // One-hot ready toward the granted producer; forced low while reset is held.
    always_comb begin
        in_ready = '0;
        if (rst_n && w_load) begin
            in_ready[w_gnt] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Output register: load on handshake, drop valid once consumed, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            r_out_last  <= 1'b0;
`endif
        end else if (w_load) begin
            r_out_data  <= w_word;
            r_out_chan  <= w_gnt;
            r_out_valid <= 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
            r_out_last  <= in_last[w_gnt];
`endif
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Arbitration state: pointer advances only on round-robin loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            r_lock      <= 1'b0;
            r_lock_chan <= '0;
`endif
        end else if (w_load && mode) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
            if (in_last[w_gnt]) begin
                r_rr_ptr <= w_ptr_next;
                r_lock   <= 1'b0;
            end else begin
                r_lock      <= 1'b1;
                r_lock_chan <= w_gnt;
            end
`else
            r_rr_ptr <= w_ptr_next;
`endif
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
`ifdef STREAM_MUX_PKT_LOCK_EN
    assign out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: a 16-channel and a 5-channel instance driven in lockstep against a
// behavioural model of the grant/handshake rules, with directed steps followed by random traffic.
module tb_stream_mux;

    localparam int NA = 16;
    localparam int NB = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NA*32-1:0] in_data_a;
    logic [NA-1:0]    in_valid_a, in_ready_a;
    logic             mode_a, out_valid_a, out_ready_a;
    logic [3:0]       sel_a, out_chan_a;
    logic [31:0]      out_data_a;
    logic [NB*32-1:0] in_data_b;
    logic [NB-1:0]    in_valid_b, in_ready_b;
    logic             mode_b, out_valid_b, out_ready_b;
    logic [2:0]       sel_b, out_chan_b;
    logic [31:0]      out_data_b;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [NA-1:0]    in_last_a;
    logic [NB-1:0]    in_last_b;
    logic             out_last_a, out_last_b;
    logic [15:0]      lst [2];
    assign in_last_a = lst[0];
    assign in_last_b = lst[1][NB-1:0];
`endif

    logic [31:0] dat [2][16];
    logic [15:0] vld [2];
    logic        md [2];
    logic        ordy [2];
    int          sl [2];

    logic        m_v [2];
    logic [31:0] m_d [2];
    int          m_c [2];
    int          m_p [2];
    logic        m_lock [2];
    int          m_lch [2];
    logic        m_l [2];

    int tests = 0;
    int fails = 0;

    always_comb begin
        in_data_a = '0;
        in_data_b = '0;
        for (int i = 0; i < NA; i++) in_data_a[i*32 +: 32] = dat[0][i];
        for (int i = 0; i < NB; i++) in_data_b[i*32 +: 32] = dat[1][i];
    end

    assign in_valid_a  = vld[0];
    assign in_valid_b  = vld[1][NB-1:0];
    assign mode_a      = md[0];
    assign mode_b      = md[1];
    assign sel_a       = sl[0][3:0];
    assign sel_b       = sl[1][2:0];
    assign out_ready_a = ordy[0];
    assign out_ready_b = ordy[1];

    stream_mux #(.N(32), .CHANNELS(NA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .mode(mode_a), .sel(sel_a),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last(in_last_a), .out_last(out_last_a),
`endif
        .out_data(out_data_a), .out_chan(out_chan_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a)
    );

    stream_mux #(.N(32), .CHANNELS(NB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .mode(mode_b), .sel(sel_b),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last(in_last_b), .out_last(out_last_b),
`endif
        .out_data(out_data_b), .out_chan(out_chan_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b)
    );

    function automatic int chans(int d);
        return (d == 0) ? NA : NB;
    endfunction

    function automatic logic [31:0] obs_rdy(int d);
        return (d == 0) ? 32'(in_ready_a) : 32'(in_ready_b);
    endfunction
    function automatic logic [31:0] obs_v(int d);
        return (d == 0) ? 32'(out_valid_a) : 32'(out_valid_b);
    endfunction
    function automatic logic [31:0] obs_d(int d);
        return (d == 0) ? out_data_a : out_data_b;
    endfunction
    function automatic logic [31:0] obs_c(int d);
        return (d == 0) ? 32'(out_chan_a) : 32'(out_chan_b);
    endfunction
`ifdef STREAM_MUX_PKT_LOCK_EN
    function automatic logic [31:0] obs_l(int d);
        return (d == 0) ? 32'(out_last_a) : 32'(out_last_b);
    endfunction
`endif

    // Reference grant: -1 means no channel is granted this cycle.
    function automatic int mgrant(int d);
        int ch = chans(d);
        if (!md[d]) return (sl[d] < ch && vld[d][sl[d]]) ? sl[d] : -1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (m_lock[d]) return vld[d][m_lch[d]] ? m_lch[d] : -1;
`endif
        for (int k = 0; k < ch; k++) begin
            if (vld[d][(m_p[d] + k) % ch]) return (m_p[d] + k) % ch;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic step();
        int   g  [2];
        logic ld [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d]  = mgrant(d);
            ld[d] = (g[d] >= 0) && (!m_v[d] || ordy[d]);
            chk($sformatf("in_ready%0d", d), obs_rdy(d), ld[d] ? (32'd1 << g[d]) : 32'd0);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (ld[d]) begin
                m_v[d] = 1'b1;
                m_d[d] = dat[d][g[d]];
                m_c[d] = g[d];
`ifdef STREAM_MUX_PKT_LOCK_EN
                m_l[d] = lst[d][g[d]];
                if (md[d]) begin
                    if (lst[d][g[d]]) begin
                        m_lock[d] = 1'b0;
                        m_p[d]    = (g[d] + 1) % chans(d);
                    end else begin
                        m_lock[d] = 1'b1;
                        m_lch[d]  = g[d];
                    end
                end
`else
                if (md[d]) m_p[d] = (g[d] + 1) % chans(d);
`endif
            end else if (ordy[d]) begin
                m_v[d] = 1'b0;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("out_valid%0d", d), obs_v(d), 32'(m_v[d]));
            chk($sformatf("out_data%0d", d), obs_d(d), m_d[d]);
            chk($sformatf("out_chan%0d", d), obs_c(d), 32'(m_c[d]));
`ifdef STREAM_MUX_PKT_LOCK_EN
            chk($sformatf("out_last%0d", d), obs_l(d), 32'(m_l[d]));
`endif
        end
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_v[d] = 1'b0; m_d[d] = '0; m_c[d] = 0; m_p[d] = 0;
            m_lock[d] = 1'b0; m_lch[d] = 0; m_l[d] = 1'b0;
            chk($sformatf("rst_valid%0d", d), obs_v(d), 32'd0);
            chk($sformatf("rst_data%0d", d), obs_d(d), 32'd0);
            chk($sformatf("rst_chan%0d", d), obs_c(d), 32'd0);
            chk($sformatf("rst_rdy%0d", d), obs_rdy(d), 32'd0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_seq [4];
        for (int d = 0; d < 2; d++) begin
            vld[d] = 16'd0; md[d] = 1'b0; sl[d] = 0; ordy[d] = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lst[d] = 16'hFFFF;
`endif
            for (int i = 0; i < 16; i++) dat[d][i] = 32'hA5A5_0000 | 32'(i) | (32'(d) << 8);
        end
        do_reset();

        // Fixed select of channel 5
        sl[0] = 5; vld[0] = 16'hFFFF;
        #1;
        chk("fix_rdy", 32'(in_ready_a), 32'h0000_0020);
        step();
        chk("fix_data", out_data_a, 32'hA5A5_0005);
        chk("fix_chan", 32'(out_chan_a), 32'd5);
        sl[0] = 15; vld[0] = 16'h7FFF;
        step();
        chk("sel_novalid", 32'(out_valid_a), 32'd0);

        // Backpressure: load, stall three cycles with the source word changing, then release
        sl[0] = 5; vld[0] = 16'hFFFF;
        step();
        ordy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dat[0][5] = 32'hB000_0000 + 32'(k);
            step();
            chk("bp_hold", out_data_a, 32'hA5A5_0005);
        end
        ordy[0] = 1'b1;
        step();
        chk("bp_next", out_data_a, 32'hB000_0002);
        dat[0][5] = 32'hC000_0000;
        step();
        chk("bp_nodup", out_data_a, 32'hC000_0000);

        // Reset while a word is held
        do_reset();

        // Round-robin over all channels
        md[0] = 1'b1; vld[0] = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            step();
            chk("rr_all", 32'(out_chan_a), 32'(i % 16));
        end
        do_reset();
        vld[0] = 16'h8101;
        exp_seq = '{0, 8, 15, 0};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_sparse", 32'(out_chan_a), 32'(exp_seq[i]));
        end

        // Five-channel wrap: park pointer at 4, then only channels 4 and 1 valid
        md[1] = 1'b1; vld[1] = 16'h0008;
        step();
        vld[1] = 16'h0012;
        exp_seq = '{4, 1, 4, 1};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rr_wrap5", 32'(out_chan_b), 32'(exp_seq[i]));
        end
        md[1] = 1'b0; sl[1] = 6; vld[1] = 16'h001F;
        step();
        chk("sel6_rdy", 32'(in_ready_b), 32'd0);
        step();
        chk("sel6_valid", 32'(out_valid_b), 32'd0);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch2 three beats with a gap, ch3 always valid
        do_reset();
        md[0] = 1'b1; vld[0] = 16'h000C; lst[0] = 16'h0000;
        step();
        chk("lock_b1", 32'(out_chan_a), 32'd2);
        step();
        chk("lock_b2", 32'(out_chan_a), 32'd2);
        vld[0] = 16'h0008;
        step();
        chk("lock_gap", 32'(out_valid_a), 32'd0);
        vld[0] = 16'h000C; lst[0] = 16'h0004;
        step();
        chk("lock_b3", 32'(out_chan_a), 32'd2);
        chk("lock_last", 32'(out_last_a), 32'd1);
        step();
        chk("lock_next", 32'(out_chan_a), 32'd3);
`endif

        // Random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 16; i++) dat[d][i] = $urandom;
                vld[d]  = (d == 0) ? 16'($urandom) : 16'($urandom & 32'h1F);
                if ($urandom_range(0, 7) == 0) md[d] = ~md[d];
                sl[d]   = (d == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 7));
                ordy[d] = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_PKT_LOCK_EN
                lst[d]  = 16'($urandom);
`endif
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
